// File: rtl/bp_mem_noc_responder.sv
// Memory-network endpoint: accepts wormhole command packets, executes reads/writes
// against a small flop-array store, and returns response packets to the requester.
module bp_mem_noc_responder #(
    parameter int flit_width_p = 64,
    parameter int cord_width_p = 8,
    parameter int len_width_p  = 4,
    parameter int addr_width_p = 16,
    parameter int els_p        = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [cord_width_p-1:0] my_cord_i,
    input  logic [flit_width_p+1:0] cmd_link_i,
    output logic [flit_width_p+1:0] cmd_link_o
);

    localparam int idx_w_lp    = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int len_lsb_lp  = cord_width_p;
    localparam int src_lsb_lp  = cord_width_p + len_width_p;
    localparam int op_bit_lp   = 2*cord_width_p + len_width_p;
    localparam int size_lsb_lp = op_bit_lp + 1;
    localparam int addr_lsb_lp = size_lsb_lp + len_width_p;

    localparam logic [2:0] e_idle     = 3'd0;
    localparam logic [2:0] e_wdata    = 3'd1;
    localparam logic [2:0] e_drain    = 3'd2;
    localparam logic [2:0] e_resp_hdr = 3'd3;
    localparam logic [2:0] e_rdata    = 3'd4;

    // Link handshake: a flit moves on any cycle where its v and the opposite
    // side's ready_and_rev are both high; v/data hold until that happens.
    logic                    cmd_v;
    logic [flit_width_p-1:0] cmd_data;
    logic                    rsp_ready;
    logic                    cmd_ready;
    logic                    rsp_v;
    logic [flit_width_p-1:0] rsp_data;
    logic                    cmd_fire;
    logic                    rsp_fire;

    assign cmd_v     = cmd_link_i[flit_width_p+1];
    assign cmd_data  = cmd_link_i[flit_width_p:1];
    assign rsp_ready = cmd_link_i[0];

    logic [2:0]              state_q, state_d;
    logic [len_width_p-1:0]  cnt_q, cnt_d;
    logic [idx_w_lp-1:0]     idx_q, idx_d;
    logic [cord_width_p-1:0] src_q, src_d;
    logic                    op_q, op_d;
    logic [len_width_p-1:0]  size_q, size_d;
    logic [addr_width_p-1:0] addr_q, addr_d;
    logic                    rdy_en_q, rdy_en_d;

    logic [flit_width_p-1:0] store_q [els_p];
    logic [flit_width_p-1:0] resp_hdr;

    logic [len_width_p-1:0]  hdr_len;
    logic                    hdr_op;
    logic [len_width_p-1:0]  hdr_size;
    logic [addr_width_p-1:0] hdr_addr;

    assign hdr_len  = cmd_data[len_lsb_lp +: len_width_p];
    assign hdr_op   = cmd_data[op_bit_lp];
    assign hdr_size = cmd_data[size_lsb_lp +: len_width_p];
    assign hdr_addr = cmd_data[addr_lsb_lp +: addr_width_p];

    // rdy_en_q keeps ready low during reset and for the release cycle itself.
    assign cmd_ready = rdy_en_q & ((state_q == e_idle) | (state_q == e_wdata) | (state_q == e_drain));
    assign rsp_v     = (state_q == e_resp_hdr) | (state_q == e_rdata);
    assign cmd_fire  = cmd_v & cmd_ready;
    assign rsp_fire  = rsp_v & rsp_ready;

    always_comb begin
        resp_hdr = '0;
        resp_hdr[0 +: cord_width_p]           = src_q;
        resp_hdr[len_lsb_lp +: len_width_p]   = op_q ? '0 : size_q;
        resp_hdr[src_lsb_lp +: cord_width_p]  = my_cord_i;
        resp_hdr[op_bit_lp]                   = op_q;
        resp_hdr[size_lsb_lp +: len_width_p]  = size_q;
        resp_hdr[addr_lsb_lp +: addr_width_p] = addr_q;
    end

    always_comb begin
        rsp_data = '0;
        if (state_q == e_resp_hdr) begin
            rsp_data = resp_hdr;
        end else if (state_q == e_rdata) begin
            rsp_data = store_q[idx_q];
        end
    end

    assign cmd_link_o = {rsp_v, rsp_data, cmd_ready};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        src_d    = src_q;
        op_d     = op_q;
        size_d   = size_q;
        addr_d   = addr_q;
        rdy_en_d = 1'b1;
        case (state_q)
            e_idle: begin
                if (cmd_fire) begin
                    src_d  = cmd_data[src_lsb_lp +: cord_width_p];
                    op_d   = hdr_op;
                    size_d = hdr_size;
                    addr_d = hdr_addr;
                    idx_d  = hdr_addr[idx_w_lp-1:0];
                    cnt_d  = (hdr_len != '0) ? hdr_len - 1'b1 : '0;
                    if (hdr_len == '0) begin
                        state_d = e_resp_hdr;
                    end else begin
                        state_d = hdr_op ? e_wdata : e_drain;
                    end
                end
            end
            e_wdata, e_drain: begin
                if (cmd_fire) begin
                    if (state_q == e_wdata) begin
                        idx_d = idx_q + 1'b1;
                    end
                    if (cnt_q == '0) begin
                        state_d = e_resp_hdr;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            e_resp_hdr: begin
                if (rsp_fire) begin
                    if (!op_q && (size_q != '0)) begin
                        state_d = e_rdata;
                        cnt_d   = size_q - 1'b1;
                        idx_d   = addr_q[idx_w_lp-1:0];
                    end else begin
                        state_d = e_idle;
                    end
                end
            end
            e_rdata: begin
                if (rsp_fire) begin
                    idx_d = idx_q + 1'b1;
                    if (cnt_q == '0) begin
                        state_d = e_idle;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= e_idle;
            cnt_q    <= '0;
            idx_q    <= '0;
            src_q    <= '0;
            op_q     <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            src_q    <= src_d;
            op_q     <= op_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            rdy_en_q <= rdy_en_d;
        end
    end

    // Store is deliberately not reset; words written before a reset survive it.
    always_ff @(posedge clk_i) begin
        if ((state_q == e_wdata) && cmd_fire) begin
            store_q[idx_q] <= cmd_data;
        end
    end

endmodule

// File: tb/tb_bp_mem_noc_responder.sv
// Directed bench for bp_mem_noc_responder: writes, wrapped bursts, drains,
// response backpressure, mid-packet reset and back-to-back packets.
module tb_bp_mem_noc_responder;

  localparam logic [7:0] my_cord = 8'h5A;

  logic        clk;
  logic        rst_n;
  logic        cmd_v;
  logic [63:0] cmd_data;
  logic        rsp_ready;
  logic [65:0] link_i;
  logic [65:0] link_o;
  logic        rsp_v;
  logic [63:0] rsp_data;
  logic        cmd_ready;

  int checks = 0;
  int errors = 0;

  assign link_i    = {cmd_v, cmd_data, rsp_ready};
  assign rsp_v     = link_o[65];
  assign rsp_data  = link_o[64:1];
  assign cmd_ready = link_o[0];

  bp_mem_noc_responder dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .my_cord_i (my_cord),
    .cmd_link_i(link_i),
    .cmd_link_o(link_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk_hdr(logic [7:0] dst, logic [3:0] len, logic [7:0] src,
                                         logic op, logic [3:0] size, logic [15:0] addr);
    logic [63:0] h;
    h = '0;
    h[40:0] = {addr, size, op, src, len, dst};
    return h;
  endfunction

  // driver: present one command flit at a negedge, return at the negedge after it is taken
  task automatic send_flit(input logic [63:0] d);
    bit ok;
    ok = 0;
    cmd_v = 1'b1;
    cmd_data = d;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout flit=%h not accepted within 50 cycles", d);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // driver: accept one response flit, return at the negedge after the transfer
  task automatic recv_flit(output logic [63:0] d);
    bit ok;
    ok = 0;
    d = 'x;
    for (int i = 0; i < 50; i++) begin
      if (rsp_v === 1'b1) begin
        ok = 1;
        d = rsp_data;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL recv_timeout no response valid within 50 cycles");
    end else begin
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_v = 1'b0;
    cmd_data = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (link_o !== 66'h0) begin
      errors++;
      $display("FAIL reset_link_o got=%h exp=0", link_o);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready got=%b exp=0", cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_v !== 1'b0) begin
      errors++;
      $display("FAIL reset_after_ready got ready=%b v=%b exp ready=1 v=0", cmd_ready, rsp_v);
    end
  endtask

  task automatic test_write_read();
    logic [63:0] d;
    send_flit(mk_hdr(8'h00, 4'd1, 8'h12, 1'b1, 4'd0, 16'd3));
    checks++;
    if (rsp_v !== 1'b0) begin
      errors++;
      $display("FAIL wr_early_ack got v=%b exp=0", rsp_v);
    end
    send_flit(64'hDEAD_BEEF);
    cmd_v = 1'b0;
    checks++;
    if (rsp_v !== 1'b1) begin
      errors++;
      $display("FAIL wr_ack_latency got v=%b exp=1 at N+2", rsp_v);
    end
    recv_flit(d);
    checks++;
    if (d !== mk_hdr(8'h12, 4'd0, my_cord, 1'b1, 4'd0, 16'd3)) begin
      errors++;
      $display("FAIL wr_ack_hdr got=%h exp=%h", d, mk_hdr(8'h12, 4'd0, my_cord, 1'b1, 4'd0, 16'd3));
    end
    send_flit(mk_hdr(8'h00, 4'd0, 8'h12, 1'b0, 4'd1, 16'd3));
    cmd_v = 1'b0;
    checks++;
    if (rsp_v !== 1'b1) begin
      errors++;
      $display("FAIL rd_hdr_latency got v=%b exp=1 at N+1", rsp_v);
    end
    recv_flit(d);
    checks++;
    if (d !== mk_hdr(8'h12, 4'd1, my_cord, 1'b0, 4'd1, 16'd3)) begin
      errors++;
      $display("FAIL rd_hdr got=%h exp=%h", d, mk_hdr(8'h12, 4'd1, my_cord, 1'b0, 4'd1, 16'd3));
    end
    recv_flit(d);
    checks++;
    if (d !== 64'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_data got=%h exp=deadbeef", d);
    end
  endtask

  task automatic test_burst_wrap();
    logic [63:0] d;
    logic [63:0] exp_w[4];
    exp_w = '{64'hA, 64'hB, 64'hC, 64'hD};
    send_flit(mk_hdr(8'h00, 4'd4, 8'h21, 1'b1, 4'd0, 16'd14));
    for (int i = 0; i < 4; i++) send_flit(exp_w[i]);
    cmd_v = 1'b0;
    recv_flit(d);
    checks++;
    if (d !== mk_hdr(8'h21, 4'd0, my_cord, 1'b1, 4'd0, 16'd14)) begin
      errors++;
      $display("FAIL burst_ack got=%h", d);
    end
    send_flit(mk_hdr(8'h00, 4'd0, 8'h21, 1'b0, 4'd4, 16'd14));
    cmd_v = 1'b0;
    recv_flit(d);
    checks++;
    if (d !== mk_hdr(8'h21, 4'd4, my_cord, 1'b0, 4'd4, 16'd14)) begin
      errors++;
      $display("FAIL burst_rd_hdr got=%h", d);
    end
    for (int i = 0; i < 4; i++) begin
      recv_flit(d);
      checks++;
      if (d !== exp_w[i]) begin
        errors++;
        $display("FAIL burst_rd_data[%0d] got=%h exp=%h", i, d, exp_w[i]);
      end
    end
    // words 0 and 1 must hold the wrapped tail of the burst
    send_flit(mk_hdr(8'h00, 4'd0, 8'h33, 1'b0, 4'd2, 16'd0));
    cmd_v = 1'b0;
    recv_flit(d);
    recv_flit(d);
    checks++;
    if (d !== 64'hC) begin
      errors++;
      $display("FAIL wrap_word0 got=%h exp=c", d);
    end
    recv_flit(d);
    checks++;
    if (d !== 64'hD) begin
      errors++;
      $display("FAIL wrap_word1 got=%h exp=d", d);
    end
    // address bits above the store index are ignored but echoed
    send_flit(mk_hdr(8'h00, 4'd0, 8'h44, 1'b0, 4'd1, 16'h001F));
    cmd_v = 1'b0;
    recv_flit(d);
    checks++;
    if (d !== mk_hdr(8'h44, 4'd1, my_cord, 1'b0, 4'd1, 16'h001F)) begin
      errors++;
      $display("FAIL high_addr_hdr got=%h", d);
    end
    recv_flit(d);
    checks++;
    if (d !== 64'hB) begin
      errors++;
      $display("FAIL high_addr_data got=%h exp=b", d);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_f[4];
    logic [3:0]  pat;
    int          k;
    int          c;
    exp_f = '{mk_hdr(8'h55, 4'd3, my_cord, 1'b0, 4'd3, 16'd14), 64'hA, 64'hB, 64'hC};
    pat = 4'b1001;
    send_flit(mk_hdr(8'h00, 4'd0, 8'h55, 1'b0, 4'd3, 16'd14));
    cmd_data = mk_hdr(8'h00, 4'd0, 8'h66, 1'b1, 4'd0, 16'd9);
    k = 0;
    c = 0;
    while (k < 4 && c < 20) begin
      checks++;
      if (rsp_v !== 1'b1 || rsp_data !== exp_f[k] || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got v=%b data=%h rdy=%b exp v=1 data=%h rdy=0",
                 c, rsp_v, rsp_data, cmd_ready, exp_f[k]);
      end
      rsp_ready = pat[c % 4];
      @(posedge clk);
      @(negedge clk);
      if (rsp_ready) k++;
      c++;
    end
    rsp_ready = 1'b0;
    cmd_v = 1'b0;
    checks++;
    if (c !== 8) begin
      errors++;
      $display("FAIL bp_cycles got=%0d exp=8", c);
    end
    @(negedge clk);
    checks++;
    if (rsp_v !== 1'b0) begin
      errors++;
      $display("FAIL bp_cmd_consumed got v=%b exp=0", rsp_v);
    end
  endtask

  task automatic test_read_drain();
    logic [63:0] d;
    send_flit(mk_hdr(8'h00, 4'd0, 8'h77, 1'b0, 4'd0, 16'd3));
    cmd_v = 1'b0;
    recv_flit(d);
    checks++;
    if (d !== mk_hdr(8'h77, 4'd0, my_cord, 1'b0, 4'd0, 16'd3)) begin
      errors++;
      $display("FAIL size0_hdr got=%h", d);
    end
    checks++;
    if (rsp_v !== 1'b0) begin
      errors++;
      $display("FAIL size0_extra got v=%b exp=0", rsp_v);
    end
    send_flit(mk_hdr(8'h00, 4'd2, 8'h78, 1'b0, 4'd1, 16'd3));
    send_flit(64'hFFFF_FFFF_FFFF_FFFF);
    checks++;
    if (rsp_v !== 1'b0) begin
      errors++;
      $display("FAIL drain_early got v=%b exp=0", rsp_v);
    end
    send_flit(64'h1234);
    cmd_v = 1'b0;
    recv_flit(d);
    checks++;
    if (d !== mk_hdr(8'h78, 4'd1, my_cord, 1'b0, 4'd1, 16'd3)) begin
      errors++;
      $display("FAIL drain_hdr got=%h", d);
    end
    recv_flit(d);
    checks++;
    if (d !== 64'hDEAD_BEEF) begin
      errors++;
      $display("FAIL drain_store got=%h exp=deadbeef", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    send_flit(mk_hdr(8'h00, 4'd4, 8'h12, 1'b1, 4'd0, 16'd8));
    send_flit(64'h11);
    send_flit(64'h22);
    cmd_data = 64'h33;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_v !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs got v=%b rdy=%b exp 0 0", rsp_v, cmd_ready);
    end
    cmd_v = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_v !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle got rdy=%b v=%b exp 1 0", cmd_ready, rsp_v);
    end
    send_flit(mk_hdr(8'h00, 4'd0, 8'h12, 1'b0, 4'd2, 16'd8));
    cmd_v = 1'b0;
    recv_flit(d);
    checks++;
    if (d !== mk_hdr(8'h12, 4'd2, my_cord, 1'b0, 4'd2, 16'd8)) begin
      errors++;
      $display("FAIL midrst_hdr got=%h", d);
    end
    recv_flit(d);
    checks++;
    if (d !== 64'h11) begin
      errors++;
      $display("FAIL midrst_word0 got=%h exp=11", d);
    end
    recv_flit(d);
    checks++;
    if (d !== 64'h22) begin
      errors++;
      $display("FAIL midrst_word1 got=%h exp=22", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] fl[4];
    logic [63:0] d;
    int k;
    int na;
    int ack_c[2];
    int hdrb_c;
    fl = '{mk_hdr(8'h00, 4'd1, 8'h31, 1'b1, 4'd0, 16'd4), 64'h55,
           mk_hdr(8'h00, 4'd1, 8'h32, 1'b1, 4'd0, 16'd5), 64'h66};
    k = 0;
    na = 0;
    ack_c = '{-1, -1};
    hdrb_c = -1;
    rsp_ready = 1'b1;
    cmd_v = 1'b1;
    cmd_data = fl[0];
    for (int c = 0; c < 12; c++) begin
      if (rsp_v === 1'b1 && na < 2) begin
        ack_c[na] = c;
        na++;
      end
      if (cmd_v && cmd_ready === 1'b1) begin
        if (k == 2) hdrb_c = c;
        k++;
      end
      @(posedge clk);
      @(negedge clk);
      if (k < 4) cmd_data = fl[k];
      else cmd_v = 1'b0;
    end
    rsp_ready = 1'b0;
    checks++;
    if (ack_c[0] !== 2 || hdrb_c !== 3 || ack_c[1] !== 5) begin
      errors++;
      $display("FAIL b2b_timing got ackA=%0d hdrB=%0d ackB=%0d exp 2 3 5", ack_c[0], hdrb_c, ack_c[1]);
    end
    send_flit(mk_hdr(8'h00, 4'd0, 8'h31, 1'b0, 4'd2, 16'd4));
    cmd_v = 1'b0;
    recv_flit(d);
    recv_flit(d);
    checks++;
    if (d !== 64'h55) begin
      errors++;
      $display("FAIL b2b_word4 got=%h exp=55", d);
    end
    recv_flit(d);
    checks++;
    if (d !== 64'h66) begin
      errors++;
      $display("FAIL b2b_word5 got=%h exp=66", d);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_burst_wrap();
    test_backpressure();
    test_read_drain();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1);
  end

endmodule
